// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch:
// FSM encoding, seven-segment patterns, BCD increment helper.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Active-low, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal ripple +1; MSB of result is carry out of digit 3
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/rise_sync.sv
// 2-flop synchronizer plus rising-edge detector.
// Ports: clk_in, rst (async high), d (async level), p (1-cycle pulse).
module rise_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic p
);

  logic s1, s2, s3;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign p = s2 & ~s3;

endmodule

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: digit (4-bit BCD), seg (bit6=g .. bit0=a); non-BCD blanks.
module seg7_decoder
  import stopwatch_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Four-digit BCD stopwatch with multiplexed 7-seg scan.
// Ports: clk_in, Reset, tick_in, start_stop, clear -> bcd, running,
// overflow, seg (active-low), an (active-low digit enables).
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk_in,
  input  logic        Reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] bcd,
  output logic        running,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  logic tick_p, ss_p, clr_p;

  rise_sync u_tick (
    .clk_in (clk_in),
    .rst    (Reset),
    .d      (tick_in),
    .p      (tick_p)
  );

  rise_sync u_ss (
    .clk_in (clk_in),
    .rst    (Reset),
    .d      (start_stop),
    .p      (ss_p)
  );

  rise_sync u_clr (
    .clk_in (clk_in),
    .rst    (Reset),
    .d      (clear),
    .p      (clr_p)
  );

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [16:0] inc;

  assign inc = bcd_inc(bcd_q);

  always_ff @(posedge clk_in or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear dominates; in RUN a tick with ss is counted before pausing
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    if (clr_p) begin
      state_d = S_IDLE;
      bcd_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ss_p) state_d = S_RUN;
        end
        S_RUN: begin
          if (tick_p) begin
            bcd_d = inc[15:0];
            if (inc[16]) ovf_d = 1'b1;
          end
          if (ss_p) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (ss_p) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign running  = (state_q == S_RUN);

  // Display scan
  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q;
  logic [3:0]    digit;
  logic [6:0]    seg_c;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;

  always_ff @(posedge clk_in or posedge Reset) begin
    if (Reset) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
    end else if (scan_q == SCAN_MAX) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + CW'(1);
    end
  end

  assign digit = bcd_q[{idx_q, 2'b00} +: 4];

  seg7_decoder u_dec (
    .digit (digit),
    .seg   (seg_c)
  );

  // an/seg trail the index by one cycle
  always_ff @(posedge clk_in or posedge Reset) begin
    if (Reset) begin
      an_q  <= 4'b1110;
      seg_q <= SEG_0;
    end else begin
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= seg_c;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter (SCAN_DIV=4).
// Table vectors through a scoreboard queue plus hand sequences.
module tb_stopwatch_counter;

  localparam int OP_SS  = 0;
  localparam int OP_TK  = 1;
  localparam int OP_CLR = 2;
  localparam int OP_TSS = 3;
  localparam int OP_ALL = 4;

  typedef struct {
    int          op;
    logic [15:0] bcd;
    logic        run;
    logic        ovf;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        Reset = 1'b1;
  logic        tick_in = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bcd;
  logic        running;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_chk = 0;
  int n_fail = 0;

  vec_t tbl [19];
  vec_t exp_q [$];

  always #5 clk_in = ~clk_in;

  stopwatch_counter #(.SCAN_DIV(4)) dut (
    .clk_in     (clk_in),
    .Reset      (Reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .bcd        (bcd),
    .running    (running),
    .overflow   (overflow),
    .seg        (seg),
    .an         (an)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int op);
    @(negedge clk_in);
    tick_in    = (op == OP_TK) || (op == OP_TSS) || (op == OP_ALL);
    start_stop = (op == OP_SS) || (op == OP_TSS) || (op == OP_ALL);
    clear      = (op == OP_CLR) || (op == OP_ALL);
    repeat (2) @(negedge clk_in);
    tick_in    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic fast_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      tick_in = 1'b1;
      repeat (2) @(negedge clk_in);
      tick_in = 1'b0;
      @(negedge clk_in);
    end
    repeat (4) @(negedge clk_in);
  endtask

  function automatic vec_t mk(input int op, input logic [15:0] b,
                              input logic r, input logic o);
    vec_t v;
    v.op = op;
    v.bcd = b;
    v.run = r;
    v.ovf = o;
    return v;
  endfunction

  initial begin
    logic [3:0] prev_an;
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    bit         found;
    vec_t       e;

    tbl[0]  = mk(OP_SS,  16'h0000, 1'b1, 1'b0);
    tbl[1]  = mk(OP_TK,  16'h0001, 1'b1, 1'b0);
    tbl[2]  = mk(OP_TK,  16'h0002, 1'b1, 1'b0);
    tbl[3]  = mk(OP_TK,  16'h0003, 1'b1, 1'b0);
    tbl[4]  = mk(OP_TK,  16'h0004, 1'b1, 1'b0);
    tbl[5]  = mk(OP_TK,  16'h0005, 1'b1, 1'b0);
    tbl[6]  = mk(OP_SS,  16'h0005, 1'b0, 1'b0);
    tbl[7]  = mk(OP_TK,  16'h0005, 1'b0, 1'b0);
    tbl[8]  = mk(OP_TK,  16'h0005, 1'b0, 1'b0);
    tbl[9]  = mk(OP_TK,  16'h0005, 1'b0, 1'b0);
    tbl[10] = mk(OP_TK,  16'h0005, 1'b0, 1'b0);
    tbl[11] = mk(OP_SS,  16'h0005, 1'b1, 1'b0);
    tbl[12] = mk(OP_TK,  16'h0006, 1'b1, 1'b0);
    tbl[13] = mk(OP_TK,  16'h0007, 1'b1, 1'b0);
    tbl[14] = mk(OP_TSS, 16'h0008, 1'b0, 1'b0);
    tbl[15] = mk(OP_TSS, 16'h0008, 1'b1, 1'b0);
    tbl[16] = mk(OP_ALL, 16'h0000, 1'b0, 1'b0);
    tbl[17] = mk(OP_TK,  16'h0000, 1'b0, 1'b0);
    tbl[18] = mk(OP_SS,  16'h0000, 1'b1, 1'b0);

    an_exp[0] = 4'b1110; seg_exp[0] = 7'b0110000;
    an_exp[1] = 4'b1101; seg_exp[1] = 7'b0100100;
    an_exp[2] = 4'b1011; seg_exp[2] = 7'b1111001;
    an_exp[3] = 4'b0111; seg_exp[3] = 7'b1000000;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_run", 32'(running), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    Reset = 1'b0;
    // First an change at edge SCAN_DIV+1
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      chk($sformatf("rst_scan_e%0d", k), 32'(an),
          (k <= 4) ? 32'hE : 32'hD);
    end

    // Table vectors through the scoreboard
    for (int i = 0; i < 19; i++) begin
      exp_q.push_back(tbl[i]);
      apply(tbl[i].op);
      if (exp_q.size() == 0) begin
        chk($sformatf("row%0d_sb_empty", i), 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d_bcd", i), 32'(bcd), 32'(e.bcd));
        chk($sformatf("row%0d_run", i), 32'(running), 32'(e.run));
        chk($sformatf("row%0d_ovf", i), 32'(overflow), 32'(e.ovf));
      end
    end

    // Increment lands exactly two edges after sampling
    @(negedge clk_in);
    tick_in = 1'b1;
    @(negedge clk_in);
    chk("lat_k", 32'(bcd), 32'h0);
    @(negedge clk_in);
    chk("lat_k1", 32'(bcd), 32'h0);
    @(negedge clk_in);
    chk("lat_k2", 32'(bcd), 32'h1);
    tick_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Rollover
    apply(OP_CLR);
    apply(OP_SS);
    fast_ticks(9999);
    chk("roll_9999", 32'(bcd), 32'h9999);
    chk("roll_pre_ovf", 32'(overflow), 32'h0);
    fast_ticks(1);
    chk("roll_bcd", 32'(bcd), 32'h0);
    chk("roll_ovf", 32'(overflow), 32'h1);
    chk("roll_run", 32'(running), 32'h1);
    apply(OP_CLR);
    chk("roll_clr_ovf", 32'(overflow), 32'h0);
    chk("roll_clr_run", 32'(running), 32'h0);
    chk("roll_clr_bcd", 32'(bcd), 32'h0);

    // Asynchronous reset mid-count
    apply(OP_SS);
    fast_ticks(42);
    chk("pre_rst_bcd", 32'(bcd), 32'h42);
    @(negedge clk_in);
    #2 Reset = 1'b1;
    #1;
    chk("arst_bcd", 32'(bcd), 32'h0);
    chk("arst_run", 32'(running), 32'h0);
    chk("arst_an", 32'(an), 32'hE);
    chk("arst_seg", 32'(seg), 32'h40);
    @(negedge clk_in);
    Reset = 1'b0;

    // Scan at 0123
    apply(OP_SS);
    fast_ticks(123);
    apply(OP_SS);
    chk("scan_bcd", 32'(bcd), 32'h123);
    found = 1'b0;
    prev_an = an;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk_in);
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      prev_an = an;
    end
    chk("scan_sync", 32'(found), 32'h1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("scan_an_d%0d_c%0d", d, c), 32'(an),
              32'(an_exp[d]));
          chk($sformatf("scan_seg_d%0d_c%0d", d, c), 32'(seg),
              32'(seg_exp[d]));
          @(negedge clk_in);
        end
      end
      chk("scan_wrap_an", 32'(an), 32'hE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
